// File: rtl/al_key_buffer_pkg.sv
// Shared keypad keycodes and key-buffer state encodings for the alarm-clock
// entry path. Optional build macro: AL_KEY_BUFFER_RANGE_CHECK_EN.
package al_key_buffer_pkg;

    // PS/2 keypad scan codes
    localparam logic [7:0] KP_0            = 8'h70;
    localparam logic [7:0] KP_1            = 8'h69;
    localparam logic [7:0] KP_2            = 8'h72;
    localparam logic [7:0] KP_3            = 8'h7A;
    localparam logic [7:0] KP_4            = 8'h6B;
    localparam logic [7:0] KP_5            = 8'h73;
    localparam logic [7:0] KP_6            = 8'h74;
    localparam logic [7:0] KP_7            = 8'h6C;
    localparam logic [7:0] KP_8            = 8'h75;
    localparam logic [7:0] KP_9            = 8'h7D;
    localparam logic [7:0] KP_STAR         = 8'h7C;
    localparam logic [7:0] KP_MINUS        = 8'h7B;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
    localparam logic [7:0] KP_INVALID      = 8'hFF;

    // Entry buffer states
    typedef enum logic [1:0] {
        KB_STATE_EMPTY  = 2'd0,
        KB_STATE_ENTRY  = 2'd1,
        KB_STATE_COMMIT = 2'd2
    } kb_state_t;

    localparam logic [2:0] KB_MAX_DIGITS = 3'd4;

    // True when HH:MM (BCD digits) is a legal 24-hour time
    function automatic logic time_in_range(input logic [3:0] h1, input logic [3:0] h0,
                                           input logic [3:0] m1, input logic [3:0] m0);
        logic [6:0] hours;
        logic [6:0] mins;
        hours = 7'({3'b000, h1} * 7'd10) + {3'b000, h0};
        mins  = 7'({3'b000, m1} * 7'd10) + {3'b000, m0};
        return (hours <= 7'd23) && (mins <= 7'd59);
    endfunction

endpackage

// File: rtl/al_key_buffer_decode.sv
// Keypad keycode to BCD digit decoder (combinational).
module kp_digit_decode
    import al_key_buffer_pkg::*;
(
    input  logic [7:0] key,
    output logic       is_digit,
    output logic [3:0] bcd
);

    // Map the ten digit scan codes to BCD; anything else is not a digit
    always_comb begin
        is_digit = 1'b1;
        bcd      = '0;
        case (key)
            KP_0:    bcd = 4'd0;
            KP_1:    bcd = 4'd1;
            KP_2:    bcd = 4'd2;
            KP_3:    bcd = 4'd3;
            KP_4:    bcd = 4'd4;
            KP_5:    bcd = 4'd5;
            KP_6:    bcd = 4'd6;
            KP_7:    bcd = 4'd7;
            KP_8:    bcd = 4'd8;
            KP_9:    bcd = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/al_key_buffer.sv
// 4-digit HH:MM keypad entry buffer feeding the alarm register and time
// counter. Digits scroll in from the right; the buffer clears after a commit
// or after TIMEOUT_SEC seconds without an accepted digit.
// Optional build macro: AL_KEY_BUFFER_RANGE_CHECK_EN (buf_valid and
// commit_done additionally require a legal 24-hour time).
module al_key_buffer
    import al_key_buffer_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk256,
    input  logic       reset,
    input  logic       one_second,
    input  logic [7:0] key,
    input  logic       alc_shift,
    input  logic       load_alarm,
    input  logic       load_new_time,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [2:0] digit_count,
    output logic       buf_valid,
    output logic       shift_err,
    output logic       commit_done
);

    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_SEC);

    kb_state_t  state, state_n;
    logic [7:0] timer, timer_n;
    logic       shift_q, load_q;
    logic       load_any, shift_rise, load_rise;
    logic       is_digit;
    logic [3:0] bcd;

    logic [3:0] ms_hr_n, ls_hr_n, ms_min_n, ls_min_n;
    logic [2:0] count_n;
    logic       valid_n, err_n, done_n, commit_ok;

    kp_digit_decode u_decode (
        .key      (key),
        .is_digit (is_digit),
        .bcd      (bcd)
    );

    assign load_any   = load_alarm | load_new_time;
    assign shift_rise = alc_shift & ~shift_q;
    assign load_rise  = load_any & ~load_q;

`ifdef AL_KEY_BUFFER_RANGE_CHECK_EN
    assign commit_ok = time_in_range(ms_hr, ls_hr, ms_min, ls_min);
`else
    assign commit_ok = 1'b1;
`endif

    // Next-state for buffer, counter and pulses; load beats shift, shift beats timeout
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        ms_hr_n  = ms_hr;
        ls_hr_n  = ls_hr;
        ms_min_n = ms_min;
        ls_min_n = ls_min;
        count_n  = digit_count;
        err_n    = 1'b0;
        done_n   = 1'b0;
        case (state)
            KB_STATE_COMMIT: begin
                state_n  = KB_STATE_EMPTY;
                timer_n  = '0;
                ms_hr_n  = '0;
                ls_hr_n  = '0;
                ms_min_n = '0;
                ls_min_n = '0;
                count_n  = '0;
            end
            default: begin
                if (load_rise) begin
                    state_n = KB_STATE_COMMIT;
                    done_n  = commit_ok;
                end else if (shift_rise && is_digit) begin
                    state_n  = KB_STATE_ENTRY;
                    timer_n  = TIMEOUT_LOAD;
                    ms_hr_n  = ls_hr;
                    ls_hr_n  = ms_min;
                    ms_min_n = ls_min;
                    ls_min_n = bcd;
                    count_n  = (digit_count >= KB_MAX_DIGITS) ? KB_MAX_DIGITS
                                                              : 3'(digit_count + 3'd1);
                end else begin
                    err_n = shift_rise;
                    if (state == KB_STATE_ENTRY) begin
                        if (timer == '0) begin
                            state_n  = KB_STATE_EMPTY;
                            ms_hr_n  = '0;
                            ls_hr_n  = '0;
                            ms_min_n = '0;
                            ls_min_n = '0;
                            count_n  = '0;
                        end else if (one_second) begin
                            timer_n = timer - 8'd1;
                        end
                    end
                end
            end
        endcase
`ifdef AL_KEY_BUFFER_RANGE_CHECK_EN
        valid_n = (count_n != '0) && time_in_range(ms_hr_n, ls_hr_n, ms_min_n, ls_min_n);
`else
        valid_n = (count_n != '0);
`endif
    end

    // Register state, edge detectors and all outputs
    always_ff @(posedge clk256) begin
        if (reset) begin
            state       <= KB_STATE_EMPTY;
            timer       <= '0;
            shift_q     <= 1'b0;
            load_q      <= 1'b0;
            ms_hr       <= '0;
            ls_hr       <= '0;
            ms_min      <= '0;
            ls_min      <= '0;
            digit_count <= '0;
            buf_valid   <= 1'b0;
            shift_err   <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            shift_q     <= alc_shift;
            load_q      <= load_any;
            ms_hr       <= ms_hr_n;
            ls_hr       <= ls_hr_n;
            ms_min      <= ms_min_n;
            ls_min      <= ls_min_n;
            digit_count <= count_n;
            buf_valid   <= valid_n;
            shift_err   <= err_n;
            commit_done <= done_n;
        end
    end

endmodule

// File: doc/al_key_buffer.md
Name: al_key_buffer

Overview:
- Downstream consumer of the alarm-clock controller's `alc_shift`, `load_alarm` and `load_new_time` strobes.
- Captures keypad digit keycodes into a 4-digit BCD entry buffer (HH:MM, digits scroll in from the right).
- Presents the buffer to the alarm register and time counter, which latch it on the controller's load strobes.
- Clears itself after each commit and after an inactivity timeout.

Parameters:
- TIMEOUT_SEC, 10, seconds of no accepted digit before the buffer auto-clears; 1..255.

Ports:
- clk256  input  1  256 Hz system clock.
- reset  input  1  synchronous, active-high reset.
- one_second  input  1  single-clk256-cycle pulse, once per second.
- key  input  8  current PS/2 keypad keycode (shared keycode header values).
- alc_shift  input  1  shift strobe from the controller; shift in the digit on `key`.
- load_alarm  input  1  controller strobe: alarm register latches the buffer.
- load_new_time  input  1  controller strobe: time counter latches the buffer.
- ms_hr  output  4  BCD tens of hours.
- ls_hr  output  4  BCD units of hours.
- ms_min  output  4  BCD tens of minutes.
- ls_min  output  4  BCD units of minutes.
- digit_count  output  3  digits entered, 0..4.
- buf_valid  output  1  buffer holds a committable time.
- shift_err  output  1  one-cycle pulse: `alc_shift` seen with a non-digit key.
- commit_done  output  1  one-cycle pulse in the COMMIT state.

Behaviour:
- Reset (synchronous, active-high, one clk256 edge):
  - all digits 0, digit_count 0, buf_valid 0, shift_err 0, commit_done 0;
  - state EMPTY, timeout counter 0;
  - edge-detect registers 0.
  - Reset mid-entry or mid-commit discards everything.
- States:
  - EMPTY: digit_count == 0.
  - ENTRY: 1..4 digits held.
  - COMMIT: single cycle.
- Accepted shift: `alc_shift` high AND `key` decodes to a digit 0..9 (KP_0..KP_9). Next edge:
  - ls_min <= decoded digit, ms_min <= ls_min, ls_hr <= ms_min, ms_hr <= ls_hr;
  - digit_count <= min(digit_count+1, 4);
  - timeout counter <= TIMEOUT_SEC;
  - state EMPTY -> ENTRY.
  - At digit_count == 4 the ms_hr digit is discarded and the count stays 4.
- `alc_shift` high with a non-digit key:
  - buffer unchanged;
  - shift_err pulses the next cycle, once per `alc_shift` rising edge.
- `alc_shift` is level-qualified by rising edge: a level held N cycles shifts exactly once.
- Commit:
  - Trigger: rising edge of (load_alarm OR load_new_time), in EMPTY or ENTRY.
  - Next edge: state COMMIT, digits unchanged, commit_done = 1.
  - Following edge: digits cleared, digit_count 0, state EMPTY.
  - Consumers sample the digits while the strobe is high and during COMMIT.
- Simultaneous shift and load rising edges: load wins; the shift is dropped, no shift_err.
- Inputs arriving in COMMIT are ignored.
- Timeout:
  - In ENTRY, each one_second pulse decrements the counter.
  - When the counter reaches 0, the next edge clears the buffer to EMPTY.
  - The counter does not run in EMPTY or COMMIT.
  - A shift in the same cycle as the final one_second reloads the counter; the buffer is not cleared.
- buf_valid = (digit_count != 0), registered with the digits. Range checking is governed by the optional feature.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: AL_KEY_BUFFER_RANGE_CHECK_EN.
- Defined:
  - buf_valid additionally requires hours (ms_hr*10 + ls_hr) <= 23 and minutes (ms_min*10 + ls_min) <= 59.
  - A commit with an out-of-range buffer still enters COMMIT but does not pulse commit_done; the buffer still clears.
- Undefined: no range check; commit_done pulses on every commit.

Decomposition:
- Shared keycode header (existing keycodes header): KP_0..KP_9, KP_STAR, KP_MINUS, KP_KEY_RELEASED, KP_INVALID.
- Add to the same header: buffer state encodings KB_STATE_EMPTY/ENTRY/COMMIT.
- One natural sub-module, `kp_digit_decode`: combinational, `key[7:0]` -> `is_digit`, `bcd[3:0]`.

Test Plan:
- Reset, then shift keys 1,2,3,4 (one `alc_shift` pulse each) -> ms_hr=1, ls_hr=2, ms_min=3, ls_min=4, digit_count=4, buf_valid=1.
- Continue with a 5th key 7 -> ms_hr=2, ls_hr=3, ms_min=4, ls_min=7, digit_count stays 4.
- Shift 0,9,3,0, then hold load_alarm high 3 cycles -> digits unchanged during COMMIT, commit_done pulses exactly once, all digits 0 and digit_count 0 two edges after the rising edge.
- `alc_shift` with key=KP_STAR in EMPTY -> shift_err single pulse, digit_count stays 0.
- One digit entered, then 10 one_second pulses with no shift -> buffer clears after the 10th; repeat with a shift on the 10th pulse -> no clear, counter reloaded.
- With AL_KEY_BUFFER_RANGE_CHECK_EN: enter 2,5,0,0 -> buf_valid=0, load_new_time gives no commit_done; enter 2,3,5,9 -> buf_valid=1, commit_done pulses.
